// File: rtl/branch_resolver_pkg.sv
// branch_resolver_pkg: shared types and constants for the branch resolver slice
package branch_resolver_pkg;
    localparam logic [31:0] INSTR_BYTES = 32'd4;
    typedef struct packed {
        logic        taken;
        logic [31:0] pc;
        logic [31:0] target;
    } bp_entry_t;
    typedef enum logic {BR_IDLE, BR_FLUSH} br_state_e;
endpackage

// File: rtl/bp_fifo.sv
// bp_fifo: in-order prediction queue with wrap-bit pointers and a bulk clear
module bp_fifo
    import branch_resolver_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  logic      clear,
    input  bp_entry_t din,
    output logic      full,
    output logic      empty,
    output bp_entry_t head
);
    localparam int AW = $clog2(DEPTH);
    bp_entry_t  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        wen;
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];
    // a clear drops any same-cycle write: it belongs to the wrong path
    assign wen   = push && !clear && !full;
    always_ff @(posedge clk)
        if (wen) mem[wr_ptr[AW-1:0]] <= din;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            rd_ptr <= clear ? wr_ptr : pop ? rd_ptr + 1'b1 : rd_ptr;
            if (wen) wr_ptr <= wr_ptr + 1'b1;
        end
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: checks fetch predictions against execute outcomes, redirects and flushes on mispredict
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        pred_valid_i,
    input  logic        pred_taken_i,
    input  logic [31:0] pred_pc_i,
    input  logic [31:0] pred_target_i,
    output logic        pred_ready_o,
    input  logic        res_valid_i,
    input  logic        res_taken_i,
    input  logic [31:0] res_pc_i,
    input  logic [31:0] res_target_i,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_o,
    output logic        err_o,
    output logic [31:0] branch_cnt_o,
    output logic [31:0] mispredict_cnt_o
);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    br_state_e   state;
    logic [CW-1:0] fcnt;
    bp_entry_t   head, wdata;
    logic        full, empty, idle, push, resolve, pc_err, mis;
    logic [31:0] corr_pc;
    assign idle         = state == BR_IDLE;
    assign pred_ready_o = !full && idle;
    assign push         = pred_valid_i && pred_ready_o;
    assign resolve      = res_valid_i && idle && !empty;
    assign pc_err       = resolve && head.pc != res_pc_i;
    assign mis          = resolve && (head.taken != res_taken_i ||
                          (res_taken_i && head.target != res_target_i) || pc_err);
    assign corr_pc      = res_taken_i ? res_target_i : res_pc_i + INSTR_BYTES;
    assign flush_o      = state == BR_FLUSH;
    assign wdata        = '{taken: pred_taken_i, pc: pred_pc_i, target: pred_target_i};
    bp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk  (clk),
        .rst  (rst_i),
        .push (push),
        .pop  (resolve),
        .clear(mis),
        .din  (wdata),
        .full (full),
        .empty(empty),
        .head (head)
    );
    always_ff @(posedge clk or posedge rst_i)
        if (rst_i) begin
            state            <= BR_IDLE;
            fcnt             <= '0;
            redirect_o       <= 1'b0;
            redirect_pc_o    <= '0;
            err_o            <= 1'b0;
            branch_cnt_o     <= '0;
            mispredict_cnt_o <= '0;
        end else begin
            redirect_o <= mis;
            err_o      <= pc_err || (res_valid_i && idle && empty);
            if (mis) redirect_pc_o <= corr_pc;
            if (resolve && ~&branch_cnt_o) branch_cnt_o <= branch_cnt_o + 32'd1;
            if (mis && ~&mispredict_cnt_o) mispredict_cnt_o <= mispredict_cnt_o + 32'd1;
            if (mis) begin
                state <= BR_FLUSH;
                fcnt  <= CW'(FLUSH_CYCLES);
            end else if (!idle) begin
                if (fcnt == CW'(1)) state <= BR_IDLE;
                fcnt <= fcnt - CW'(1);
            end
        end
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed stimulus checked every cycle against a queue-based reference model
module tb_branch_resolver;
    import branch_resolver_pkg::*;
    localparam int DEPTH = 4;
    localparam int FLUSH_CYCLES = 2;
    logic        clk = 1'b0, rst = 1'b1;
    logic        pred_valid_i = 0, pred_taken_i = 0, res_valid_i = 0, res_taken_i = 0;
    logic [31:0] pred_pc_i = 0, pred_target_i = 0, res_pc_i = 0, res_target_i = 0;
    logic        pred_ready_o, redirect_o, flush_o, err_o;
    logic [31:0] redirect_pc_o, branch_cnt_o, mispredict_cnt_o;
    int total = 0, bad = 0;
    bp_entry_t mq[$];
    int          fl;
    logic        e_red, e_err;
    logic [31:0] e_pc, e_b, e_m;

    branch_resolver #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk(clk), .rst_i(rst),
        .pred_valid_i(pred_valid_i), .pred_taken_i(pred_taken_i),
        .pred_pc_i(pred_pc_i), .pred_target_i(pred_target_i), .pred_ready_o(pred_ready_o),
        .res_valid_i(res_valid_i), .res_taken_i(res_taken_i),
        .res_pc_i(res_pc_i), .res_target_i(res_target_i),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .flush_o(flush_o),
        .err_o(err_o), .branch_cnt_o(branch_cnt_o), .mispredict_cnt_o(mispredict_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h @%0t", name, act, exp, $time);
        end
    endtask

    // reference: a plain queue of outstanding predictions plus a flush countdown
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            fl = 0; e_red = 0; e_err = 0; e_pc = 0; e_b = 0; e_m = 0;
        end else begin
            e_red = 0;
            e_err = 0;
            if (fl > 0) fl--;
            else begin
                bit can, wrong;
                bp_entry_t h;
                can = pred_valid_i && mq.size() < DEPTH;
                if (res_valid_i && mq.size() == 0) e_err = 1;
                else if (res_valid_i) begin
                    h = mq.pop_front();
                    if (e_b != 32'hFFFF_FFFF) e_b++;
                    wrong = h.taken != res_taken_i || h.pc != res_pc_i ||
                            (res_taken_i && h.target != res_target_i);
                    if (h.pc != res_pc_i) e_err = 1;
                    if (wrong) begin
                        if (e_m != 32'hFFFF_FFFF) e_m++;
                        e_red = 1;
                        e_pc = res_taken_i ? res_target_i : res_pc_i + 32'd4;
                        fl = FLUSH_CYCLES;
                        mq.delete();
                        can = 0;
                    end
                end
                if (can) mq.push_back('{pred_taken_i, pred_pc_i, pred_target_i});
            end
        end
    end

    always @(posedge clk) begin
        #2;
        check("m_redirect", redirect_o, e_red);
        check("m_redirect_pc", redirect_pc_o, e_pc);
        check("m_flush", flush_o, fl > 0);
        check("m_err", err_o, e_err);
        check("m_ready", pred_ready_o, mq.size() < DEPTH && fl == 0);
        check("m_branch_cnt", branch_cnt_o, e_b);
        check("m_mis_cnt", mispredict_cnt_o, e_m);
    end

    task automatic drive(input logic pv, input logic pt, input logic [31:0] ppc, input logic [31:0] ptg,
                         input logic rv, input logic rt, input logic [31:0] rpc, input logic [31:0] rtg);
        @(negedge clk);
        pred_valid_i = pv; pred_taken_i = pt; pred_pc_i = ppc; pred_target_i = ptg;
        res_valid_i = rv; res_taken_i = rt; res_pc_i = rpc; res_target_i = rtg;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_redirect", redirect_o, 0);
        check("rst_flush", flush_o, 0);
        check("rst_err", err_o, 0);
        check("rst_pc", redirect_pc_o, 0);
        check("rst_bcnt", branch_cnt_o, 0);
        rst = 0;
        // correct backward branch
        drive(1, 1, 32'h100, 32'hF0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 32'h100, 32'hF0);
        idle();
        check("ok_redirect", redirect_o, 0);
        check("ok_bcnt", branch_cnt_o, 1);
        check("ok_mcnt", mispredict_cnt_o, 0);
        // wrong direction
        drive(1, 1, 32'h200, 32'h1C0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 32'h200, 0);
        idle();
        check("wd_redirect", redirect_o, 1);
        check("wd_pc", redirect_pc_o, 32'h204);
        check("wd_flush1", flush_o, 1);
        idle();
        check("wd_flush2", flush_o, 1);
        check("wd_ready", pred_ready_o, 0);
        idle();
        check("wd_flush_end", flush_o, 0);
        check("wd_mcnt", mispredict_cnt_o, 1);
        // forward taken with same-cycle wrong-path push
        drive(1, 0, 32'h300, 0, 0, 0, 0, 0);
        drive(1, 1, 32'h308, 32'h2F0, 1, 1, 32'h300, 32'h340);
        idle();
        check("fw_pc", redirect_pc_o, 32'h340);
        check("fw_ready", pred_ready_o, 0);
        idle();
        idle();
        drive(0, 0, 0, 0, 1, 1, 32'h308, 32'h2F0);
        idle();
        check("empty_err", err_o, 1);
        check("empty_redirect", redirect_o, 0);
        check("empty_bcnt", branch_cnt_o, 3);
        // fill, refuse, then wrap through the pointers
        for (int i = 0; i < 4; i++)
            drive(1, (i % 2) == 1, 32'h1000 + 8 * i, 32'h2000 + 16 * i, 0, 0, 0, 0);
        idle();
        check("full_ready", pred_ready_o, 0);
        drive(1, 1, 32'hDEAD0000, 32'hBEEF0000, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 0, 0, 1, (k % 2) == 1, 32'h1000 + 8 * k, 32'h2000 + 16 * k);
            drive(1, ((k + 4) % 2) == 1, 32'h1000 + 8 * (k + 4), 32'h2000 + 16 * (k + 4), 0, 0, 0, 0);
        end
        for (int k = 10; k < 14; k++)
            drive(0, 0, 0, 0, 1, (k % 2) == 1, 32'h1000 + 8 * k, 32'h2000 + 16 * k);
        idle();
        check("wrap_bcnt", branch_cnt_o, 17);
        check("wrap_mcnt", mispredict_cnt_o, 2);
        // PC mismatch: error plus redirect
        drive(1, 1, 32'h500, 32'h540, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 32'h504, 32'h540);
        idle();
        check("pce_err", err_o, 1);
        check("pce_redirect", redirect_o, 1);
        check("pce_pc", redirect_pc_o, 32'h540);
        idle();
        idle();
        idle();
        // asynchronous reset during the first flush cycle
        drive(1, 0, 32'h600, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 32'h600, 32'h680);
        @(posedge clk);
        #3;
        pred_valid_i = 0; res_valid_i = 0;
        check("pre_rst_flush", flush_o, 1);
        rst = 1;
        #1;
        check("arst_flush", flush_o, 0);
        check("arst_redirect", redirect_o, 0);
        check("arst_bcnt", branch_cnt_o, 0);
        check("arst_mcnt", mispredict_cnt_o, 0);
        @(negedge clk);
        rst = 0;
        idle();
        check("arst_ready", pred_ready_o, 1);
        idle();
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
